// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment scanner with a double-buffered frame (shadow -> active on wrap).
// Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZB_EN.
module seg_scan #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_blank,
    output logic        wr_ready,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp,
    output logic [7:0]  ds,
    output logic        frame_tick
);
    localparam int PW = $clog2(DIV);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          pending, pending_nxt;
    logic [31:0]   sh_data, act_data;
    logic [7:0]    sh_dp, sh_blank, act_dp, act_blank;
    logic          wrap_d;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [7:0]    ds_q;

    logic        last, wrap, accept, swap;
    logic [31:0] upper;
    logic [3:0]  nib;
    logic        blank_cur;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        last   = en && (presc == PW'(DIV - 1));
        wrap   = last && (idx == 3'd7);
        accept = wr_valid && wr_ready;
        swap   = wrap && pending;
        pending_nxt = pending;
        if (accept)
            pending_nxt = 1'b1;
        else if (swap)
            pending_nxt = 1'b0;
        // Current nibble and all higher ones, for leading-zero detection
        upper = act_data >> {idx, 2'b00};
        nib   = upper[3:0];
`ifdef SEG_SCAN_LZB_EN
        blank_cur = act_blank[idx] || ((idx != 3'd0) && (upper == 32'd0) && !act_dp[idx]);
`else
        blank_cur = act_blank[idx];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            wr_ready   <= 1'b1;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= 8'hFF;
            wrap_d     <= 1'b0;
            frame_tick <= 1'b0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            ds_q       <= 8'hFF;
        end else begin
            if (en) begin
                presc <= last ? '0 : presc + PW'(1);
                if (last)
                    idx <= idx + 3'd1;
            end
            if (accept) begin
                sh_data  <= wr_data;
                sh_dp    <= wr_dp;
                sh_blank <= wr_blank;
            end
            if (swap) begin
                act_data  <= sh_data;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
            end
            pending  <= pending_nxt;
            wr_ready <= !pending_nxt;
            // Tick is delayed to line up with the first slot of the new frame on the outputs
            wrap_d     <= wrap;
            frame_tick <= wrap_d && en;
            if (en && !blank_cur) begin
                ds_q  <= ~(8'd1 << idx);
                seg_q <= glyph(nib);
                dp_q  <= act_dp[idx];
            end else begin
                ds_q  <= 8'hFF;
                seg_q <= '0;
                dp_q  <= 1'b0;
            end
        end
    end

    assign {g, f, e, d, c, b, a} = seg_q;
    assign dp = dp_q;
    assign ds = ds_q;
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (DIV=4): expected per-slot display words are queued at write time
// and popped as each scan slot appears on the outputs.
module tb_seg_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_dp = '0;
    logic [7:0]  wr_blank = '0;
    logic        wr_ready, a, b, c, d, e, f, g, dp, frame_tick;
    logic [7:0]  ds;

    int checks = 0;
    int failures = 0;
    logic [15:0] sb[$];
    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    wire [15:0]  obs = {ds, dp, g, f, e, d, c, b, a};

    seg_scan #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_dp(wr_dp), .wr_blank(wr_blank), .wr_ready(wr_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
        .ds(ds), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    // Display word {ds, dp, g..a} a correct scanner shows for digit k of a frame
    function automatic logic [15:0] exp_slot(input logic [31:0] dt, input logic [7:0] p,
                                             input logic [7:0] bl, input int k);
        logic [31:0] up;
        logic        blk;
        logic [7:0]  one;
        up  = dt >> (4 * k);
        blk = bl[k];
`ifdef SEG_SCAN_LZB_EN
        if (k > 0 && up == 32'd0 && !p[k]) blk = 1'b1;
`endif
        one = 8'd1 << k;
        if (blk) return 16'hFF00;
        return {~one, p[k], glyph_tab[up[3:0]]};
    endfunction

    task automatic push_frame(input logic [31:0] dt, input logic [7:0] p, input logic [7:0] bl);
        for (int k = 0; k < 8; k++) sb.push_back(exp_slot(dt, p, bl, k));
    endtask

    task automatic do_write(input logic [31:0] dt, input logic [7:0] p, input logic [7:0] bl);
        logic rdy;
        int n;
        n = 0;
        wr_valid = 1'b1; wr_data = dt; wr_dp = p; wr_blank = bl;
        do begin
            rdy = wr_ready;
            tick();
            n++;
        end while (!rdy && n < 200);
        wr_valid = 1'b0;
        check("write_accept", {31'd0, rdy}, 32'd1);
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin tick(); n++; end while (frame_tick !== 1'b1 && n < 200);
        check(tag, {31'd0, frame_tick}, 32'd1);
    endtask

    // Called at the first cycle of slot 0; compares each slot at its start, 4 cycles apart
    task automatic check_slots(input string tag);
        logic [15:0] x;
        for (int k = 0; k < 8; k++) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, sb.size(), 32'd8);
                return;
            end
            x = sb.pop_front();
            check($sformatf("%s_slot%0d", tag, k), {16'd0, obs}, {16'd0, x});
            tick();
            if (k == 0) check({tag, "_tick_width"}, {31'd0, frame_tick}, 32'd0);
            repeat (3) tick();
        end
    endtask

    initial begin
        int acc_wait;
        // Reset state
        repeat (3) tick();
        check("rst_outputs", {15'd0, obs, frame_tick}, {15'd0, 16'hFF00, 1'b0});
        check("rst_ready", {31'd0, wr_ready}, 32'd1);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, wr_ready}, 32'd1);
        check("post_rst_dark", {16'd0, obs}, 32'h0000FF00);

        // First frame: all 16 glyph cases across two scans
        do_write(32'h89ABCDEF, 8'h00, 8'h00);
        push_frame(32'h89ABCDEF, 8'h00, 8'h00);
        wait_tick("tick_f1");
        check_slots("f1");

        // Back-to-back writes: second held off until after the swap
        do_write(32'h01234567, 8'h81, 8'h00);
        check("b2b_held", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b1; wr_data = 32'h76543210; wr_dp = 8'h24; wr_blank = 8'h00;
        acc_wait = 0;
        while (wr_ready !== 1'b1 && acc_wait < 200) begin
            check("b2b_no_tick_early", {31'd0, frame_tick}, 32'd0);
            tick();
            acc_wait++;
        end
        tick();
        wr_valid = 1'b0;
        check("b2b_tick_after_accept", {31'd0, frame_tick}, 32'd1);
        check("b2b_ready_low_again", {31'd0, wr_ready}, 32'd0);
        push_frame(32'h01234567, 8'h81, 8'h00);
        check_slots("b2b_a");
        push_frame(32'h76543210, 8'h24, 8'h00);
        wait_tick("tick_b2b_b");
        check_slots("b2b_b");

        // Explicit blanking of the low four digits
        do_write(32'h12345678, 8'h00, 8'h0F);
        push_frame(32'h12345678, 8'h00, 8'h0F);
        wait_tick("tick_blank");
        check_slots("blank");

        // Scan pause mid-slot 3, then resume at the held count
        do_write(32'hFEDCBA98, 8'h08, 8'h00);
        push_frame(32'hFEDCBA98, 8'h08, 8'h00);
        wait_tick("tick_pause");
        check_slots("pause_pre");
        repeat (13) tick();
        check("pause_slot3_start", {16'd0, obs}, {16'd0, exp_slot(32'hFEDCBA98, 8'h08, 8'h00, 3)});
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("pause_dark%0d", i), {15'd0, obs, frame_tick}, {15'd0, 16'hFF00, 1'b0});
        end
        en = 1'b1;
        tick();
        check("resume_slot3_a", {16'd0, obs}, {16'd0, exp_slot(32'hFEDCBA98, 8'h08, 8'h00, 3)});
        tick();
        check("resume_slot3_b", {16'd0, obs}, {16'd0, exp_slot(32'hFEDCBA98, 8'h08, 8'h00, 3)});
        tick();
        check("resume_slot4", {16'd0, obs}, {16'd0, exp_slot(32'hFEDCBA98, 8'h08, 8'h00, 4)});

        // Zeros: auto-blanked only with leading-zero blanking compiled in
        do_write(32'h00000405, 8'h00, 8'h00);
        push_frame(32'h00000405, 8'h00, 8'h00);
        wait_tick("tick_lzb");
        check_slots("lzb");

        // Reset while a frame is pending discards it
        repeat (6) tick();
        do_write(32'h55555555, 8'hFF, 8'h00);
        check("pend_before_rst", {31'd0, wr_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_dark", {16'd0, obs}, 32'h0000FF00);
        check("rst_async_ready", {31'd0, wr_ready}, 32'd1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst2_ready", {31'd0, wr_ready}, 32'd1);
        push_frame(32'h0, 8'h00, 8'hFF);
        wait_tick("tick_after_rst");
        check_slots("discard");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000, meaning clock cycles each digit is lit per scan slot; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  scan enable; low = display dark, counters hold.
REQ-005 wr_valid  input  1  new display frame offered.
REQ-006 wr_data  input  32  eight hex nibbles; digit k = wr_data[4k+3:4k].
REQ-007 wr_dp  input  8  decimal point per digit, 1 = lit.
REQ-008 wr_blank  input  8  per-digit blank, 1 = digit dark.
REQ-009 wr_ready  output  1  shadow register free; write accepted when wr_valid && wr_ready.
REQ-010 a, b, c, d, e, f, g, dp  output  1 each  segment drives, active-high.
REQ-011 ds  output  8  digit selects, active-low; ds[k]=0 lights digit k.
REQ-012 frame_tick  output  1  one-cycle pulse at end of each full 8-digit scan.

Function
REQ-013 Prescaler counts 0..DIV-1 while en=1; digit index idx (3 bits) increments, wrapping 7->0, on the cycle prescaler = DIV-1.
REQ-014 All outputs are registered; they reflect idx and the active frame one cycle after idx changes.
REQ-015 For current digit k not blanked: ds = ~(1<<k), segments = glyph(nibble k), dp = active dp[k].
REQ-016 Glyph {g,f,e,d,c,b,a} hex 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-017 Blanked digit (active blank[k]=1): ds = 8'hFF, all segments and dp = 0 for that slot; scan timing unchanged.
REQ-018 Write handshake: accepted write loads shadow {data,dp,blank}, sets pending, wr_ready = 0 from next cycle.
REQ-019 Frame swap: on the cycle idx wraps 7->0 with pending=1, shadow copies to active and pending clears; no tearing mid-frame.
REQ-020 wr_ready = !pending, registered; a write cannot be accepted in the swap cycle; earliest next acceptance is the cycle after.
REQ-021 frame_tick = 1 for exactly the cycle after idx wraps 7->0; coincides with swap visibility.
REQ-022 en=0: prescaler and idx hold, ds = 8'hFF, segments and dp = 0, frame_tick = 0; writes still accepted into shadow; swap deferred until scan resumes and wraps.
REQ-023 en deasserted and reasserted resumes at the held idx and prescaler value, no skip.

Reset
REQ-024 rst=1 asynchronously forces: prescaler 0, idx 0, pending 0, wr_ready 1, active data 0, dp 0, blank 8'hFF, shadow 0.
REQ-025 During and after reset until first swap: ds = 8'hFF, all segments and dp = 0, frame_tick = 0.
REQ-026 Reset mid-write discards any pending frame; wr_ready = 1 in the first cycle after release.

Configuration
REQ-027 Macro SEG_SCAN_LZB_EN: when defined, leading-zero blanking applies: a digit k>0 is also blanked if nibble k and all higher nibbles are 0 and its dp bit is 0; digit 0 never auto-blanked.
REQ-028 Without SEG_SCAN_LZB_EN only wr_blank controls blanking; zeros display as glyph 3F.

Verification
REQ-029 DIV=4, reset, write data=32'h89ABCDEF, dp=0, blank=0 -> after next wrap ds cycles FE,FD,...,7F every 4 cycles, digit 0 segs 71, digit 7 segs 7F.
REQ-030 Two writes back to back -> second held off (wr_ready=0) until cycle after swap; second frame visible one full scan later.
REQ-031 blank=8'h0F, data=32'h12345678 -> ds = FF in slots 0-3; slot 4 shows 4 (segs 66) with ds=EF.
REQ-032 en low for 10 cycles mid-slot 3 -> ds=FF, no frame_tick; on resume slot 3 completes remaining prescaler count.
REQ-033 rst pulse while pending=1 mid-scan -> outputs dark immediately, wr_ready=1, old shadow never displayed.
REQ-034 With SEG_SCAN_LZB_EN, data=32'h00000405, dp=0 -> digits 3..7 dark, digit 2 shows 4, digit 1 shows 0 (3F), digit 0 shows 5 (6D).
